// File: rtl/cavlc_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_bit_packer
// Purpose  : Packs variable-length CAVLC codes MSB-first into 32-bit
//            big-endian words, with byte-aligned flush and last-word marking.
// Revision : 1.0 - initial release
// ============================================================================
module cavlc_bit_packer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             code_valid,
    output logic             code_ready,
    input  logic [IN_W-1:0]  code_bits,
    input  logic [5:0]       code_len,
    input  logic             flush,
    output logic             flush_busy,
    output logic             flush_done,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [OUT_W-1:0] word_data,
    output logic [2:0]       word_bytes,
    output logic             word_last,
    output logic [31:0]      bit_count
);
    localparam int c_ACC_W = 2 * OUT_W;
    // One spare bit so a 63-bit fill can round up to 64 during padding.
    localparam int c_CNT_W = $clog2(c_ACC_W) + 1;
    localparam logic [c_CNT_W-1:0] c_WORD_BITS = c_CNT_W'(OUT_W);
    localparam logic [c_CNT_W-1:0] c_BYTE_M1   = c_CNT_W'(7);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_PAD   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] w_acc_base;
    logic [c_ACC_W-1:0] w_code_ext;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_base;
    logic [c_CNT_W-1:0] w_cnt_pad;
    logic [c_CNT_W-1:0] w_shift;
    logic [IN_W-1:0]    w_code;
    logic               r_word_valid;
    logic [OUT_W-1:0]   r_word_data;
    logic [2:0]         r_word_bytes;
    logic               r_word_last;
    logic               r_flush_done;
    logic [31:0]        r_bit_count;
    logic               w_slot_free;
    logic               w_accept;
    logic               w_drain_full;
    logic               w_drain_last;
    logic               w_done;

    assign w_slot_free = !r_word_valid || word_ready;
    assign code_ready  = !rst && (r_state == c_RUN) &&
                         ((r_cnt < c_WORD_BITS) || w_slot_free);
    assign w_accept    = code_valid && code_ready;

    assign w_acc_base  = w_drain_full ? (r_acc << OUT_W) : r_acc;
    assign w_cnt_base  = w_drain_full ? (r_cnt - c_WORD_BITS) : r_cnt;
    // Masked code lands directly below the fill point left after any drain.
    assign w_code      = code_bits & ~({IN_W{1'b1}} << code_len);
    assign w_shift     = c_CNT_W'(c_ACC_W) - w_cnt_base - c_CNT_W'(code_len);
    assign w_code_ext  = c_ACC_W'(w_code) << w_shift;
    assign w_cnt_pad   = (r_cnt + c_BYTE_M1) & ~c_BYTE_M1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_drain_full = 1'b0;
        w_drain_last = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_RUN: begin
                w_drain_full = (r_cnt >= c_WORD_BITS) && w_slot_free;
                if (flush) begin
                    w_state_next = c_PAD;
                end
            end
            c_PAD: begin
                w_state_next = c_DRAIN;
            end
            c_DRAIN: begin
                if (r_cnt > c_WORD_BITS) begin
                    w_drain_full = w_slot_free;
                end else if (r_cnt == '0) begin
                    w_state_next = c_DONE;
                end else if (w_slot_free) begin
                    w_drain_last = 1'b1;
                    w_state_next = c_DONE;
                end
            end
            default: begin
                if (w_slot_free) begin
                    w_done       = 1'b1;
                    w_state_next = c_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_word_valid <= 1'b0;
            r_word_data  <= '0;
            r_word_bytes <= '0;
            r_word_last  <= 1'b0;
            r_flush_done <= 1'b0;
            r_bit_count  <= '0;
        end else begin
            r_flush_done <= w_done;
            if (w_drain_full || w_drain_last) begin
                r_word_valid <= 1'b1;
                r_word_data  <= r_acc[c_ACC_W-1 -: OUT_W];
                r_word_bytes <= w_drain_last ? 3'(r_cnt >> 3) : 3'(OUT_W / 8);
                r_word_last  <= w_drain_last;
            end else if (word_ready) begin
                r_word_valid <= 1'b0;
            end

            if (r_state == c_PAD) begin
                r_cnt <= w_cnt_pad;
            end else if (w_drain_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_base | (w_accept ? w_code_ext : '0);
                r_cnt <= w_cnt_base + (w_accept ? c_CNT_W'(code_len) : '0);
            end

            if (w_accept) begin
                r_bit_count <= r_bit_count + 32'(code_len);
            end
        end
    end

    assign flush_busy = (r_state != c_RUN);
    assign flush_done = r_flush_done;
    assign word_valid = r_word_valid;
    assign word_data  = r_word_data;
    assign word_bytes = r_word_bytes;
    assign word_last  = r_word_last;
    assign bit_count  = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cavlc_bit_packer
// Purpose  : Directed and random stimulus for cavlc_bit_packer against a
//            bit-queue stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cavlc_bit_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic        code_valid;
    logic        code_ready;
    logic [31:0] code_bits;
    logic [5:0]  code_len;
    logic        flush;
    logic        flush_busy;
    logic        flush_done;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic [2:0]  word_bytes;
    logic        word_last;
    logic [31:0] bit_count;

    cavlc_bit_packer #(.IN_W(32), .OUT_W(32)) dut (
        .clk(clk), .rst(rst),
        .code_valid(code_valid), .code_ready(code_ready),
        .code_bits(code_bits), .code_len(code_len),
        .flush(flush), .flush_busy(flush_busy), .flush_done(flush_done),
        .word_valid(word_valid), .word_ready(word_ready),
        .word_data(word_data), .word_bytes(word_bytes),
        .word_last(word_last), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        last;
    } word_t;

    bit          bitq[$];     // stream bits accepted but not yet delivered
    word_t       hs_log[$];   // words seen handshaking in the current scenario
    logic [31:0] exp_bits;
    bit          flush_pending;
    bit          done_seen;
    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          hs_cyc = 0;
    int          done_cyc = 0;
    int          n_acc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic cv, input logic [31:0] cb, input logic [5:0] cl,
                       input logic fl, input logic wr);
        logic  acc_s;
        logic  held;
        word_t obs;
        word_t expw;
        int    n;
        code_valid = cv; code_bits = cb; code_len = cl; flush = fl; word_ready = wr;
        #1;
        assert (!(cv && cl > 6'd32)) else $fatal(1, "FAIL illegal_code_len %0d", cl);
        acc_s = cv && code_ready;
        obs   = {word_data, word_bytes, word_last};
        held  = word_valid && !wr;
        if (flush_done) begin
            chk("flush_done_ctx", {63'b0, flush_pending && bitq.size() == 0}, 64'd1);
            flush_pending = 0;
            done_seen     = 1;
            done_cyc      = cyc_n;
        end
        chk("flush_busy", {63'b0, flush_busy}, {63'b0, flush_pending});
        if (flush_pending) chk("code_ready_busy", {63'b0, code_ready}, 64'd0);
        if (word_valid && wr) begin
            n    = bitq.size();
            expw = '0;
            // A final word of exactly 32 bits may legitimately go out as a plain word
            if (flush_pending && n <= 32 && !(n == 32 && !word_last)) begin
                for (int i = 0; i < n; i++) expw.data[31-i] = bitq[i];
                expw.bytes = 3'((n + 7) / 8);
                expw.last  = 1'b1;
                bitq.delete();
            end else begin
                for (int i = 0; i < 32 && i < n; i++) expw.data[31-i] = bitq[i];
                expw.bytes = 3'd4;
                repeat (n < 32 ? n : 32) void'(bitq.pop_front());
            end
            chk("word", 64'(obs), 64'(expw));
            hs_log.push_back(obs);
            hs_cyc = cyc_n;
        end
        if (acc_s) n_acc++;
        @(posedge clk);
        #1;
        if (acc_s) begin
            for (int i = int'(cl) - 1; i >= 0; i--) bitq.push_back(cb[i]);
            exp_bits += 32'(cl);
        end
        if (fl && !flush_pending) flush_pending = 1;
        chk("bit_count", 64'(bit_count), 64'(exp_bits));
        if (held) chk("word_hold", 64'({word_valid, word_data, word_bytes, word_last}),
                      64'({1'b1, obs}));
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; code_valid = 1'b1; code_bits = '1; code_len = 6'd1;
        flush = 1'b0; word_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_code_ready", {63'b0, code_ready}, 64'd0);
        chk("rst_outputs", 64'({word_valid, word_data, word_bytes, word_last}), 64'd0);
        chk("rst_flush", {62'b0, flush_busy, flush_done}, 64'd0);
        chk("rst_bit_count", 64'(bit_count), 64'd0);
        bitq.delete();
        exp_bits      = '0;
        flush_pending = 0;
        @(negedge clk);
        rst = 1'b0; code_valid = 1'b0;
        hs_log.delete();
        n_acc = 0;
    endtask

    task automatic flush_and_wait(input string tag);
        done_seen = 0;
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 200 && !done_seen; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk(tag, {63'b0, done_seen}, 64'd1);
    endtask

    logic [31:0] bp_codes[3];
    int          idx;

    initial begin
        rst = 1'b1; code_valid = 1'b0; code_bits = '0; code_len = '0;
        flush = 1'b0; word_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Fill to one word with single one-bits
        for (int i = 0; i < 32; i++) cyc(1'b1, 32'd1, 6'd1, 1'b0, 1'b1);
        chk("fill_n_acc", 64'(n_acc), 64'd32);
        chk("fill_not_yet", {63'b0, word_valid}, 64'd0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        chk("fill_word", 64'({word_valid, word_data, word_bytes, word_last}),
            64'({1'b1, 32'hFFFF_FFFF, 3'd4, 1'b0}));
        chk("fill_bit_count", 64'(bit_count), 64'd32);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Single short code then flush
        do_reset();
        cyc(1'b1, 32'b000011, 6'd6, 1'b0, 1'b1);
        flush_and_wait("single_done");
        chk("single_count", 64'(hs_log.size()), 64'd1);
        if (hs_log.size() > 0)
            chk("single_word", 64'(hs_log[0]), 64'({32'h0C00_0000, 3'd1, 1'b1}));
        chk("single_done_lat", 64'(done_cyc), 64'(hs_cyc + 1));
        chk("single_bits", 64'(bit_count), 64'd6);

        // Backpressure with three full-width codes
        do_reset();
        bp_codes = '{32'hAAAA_AAAA, 32'h5555_5555, 32'h1234_5678};
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, bp_codes[idx], 6'd32, 1'b0, 1'b0);
            idx = n_acc;
        end
        chk("bp_accepts", 64'(n_acc), 64'd2);
        chk("bp_ready_low", {63'b0, code_ready}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            if (idx < 3) cyc(1'b1, bp_codes[idx], 6'd32, 1'b0, 1'b1);
            else         cyc(1'b0, '0, '0, 1'b0, 1'b1);
            idx = n_acc;
        end
        chk("bp_accepts_all", 64'(n_acc), 64'd3);
        chk("bp_words", 64'(hs_log.size()), 64'd3);
        if (hs_log.size() == 3) begin
            chk("bp_w0", 64'(hs_log[0].data), 64'h0000_0000_AAAA_AAAA);
            chk("bp_w1", 64'(hs_log[1].data), 64'h0000_0000_5555_5555);
            chk("bp_w2", 64'(hs_log[2].data), 64'h0000_0000_1234_5678);
        end

        // Codes straddling a word boundary
        do_reset();
        cyc(1'b1, 32'h5, 6'd3, 1'b0, 1'b1);
        cyc(1'b1, 32'h1FFF_FFFF, 6'd29, 1'b0, 1'b1);
        cyc(1'b1, 32'h3, 6'd2, 1'b0, 1'b1);
        flush_and_wait("straddle_done");
        chk("straddle_count", 64'(hs_log.size()), 64'd2);
        if (hs_log.size() == 2) begin
            chk("straddle_w0", 64'(hs_log[0]), 64'({32'hBFFF_FFFF, 3'd4, 1'b0}));
            chk("straddle_w1", 64'(hs_log[1]), 64'({32'hC000_0000, 3'd1, 1'b1}));
        end

        // Zero-length code and empty flush
        do_reset();
        cyc(1'b1, 32'h0000_FFFF, 6'd0, 1'b0, 1'b1);
        chk("zlen_accept", 64'(n_acc), 64'd1);
        flush_and_wait("empty_done");
        chk("empty_no_word", 64'(hs_log.size()), 64'd0);
        chk("empty_ready", {63'b0, code_ready}, 64'd1);
        cyc(1'b1, 32'h1, 6'd1, 1'b0, 1'b1);
        flush_and_wait("zlen_after_done");
        if (hs_log.size() == 1)
            chk("zlen_after_word", 64'(hs_log[0]), 64'({32'h8000_0000, 3'd1, 1'b1}));
        else
            chk("zlen_after_count", 64'(hs_log.size()), 64'd1);

        // Reset in the middle of a partial word
        do_reset();
        cyc(1'b1, 32'h7F, 6'd7, 1'b0, 1'b1);
        do_reset();
        flush_and_wait("rst_mid_done");
        chk("rst_mid_no_word", 64'(hs_log.size()), 64'd0);

        // Random traffic with random backpressure and occasional flushes
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, 6'($urandom_range(0, 32)),
                !flush_pending && ($urandom_range(0, 59) == 0),
                $urandom_range(0, 9) < 7);
        end
        flush_and_wait("rand_final_done");
        chk("rand_drained", 64'(bitq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
